regfile_write_arbiter: RTL

//  Shares the single write port of the 8x8 register file between two writeback

---
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback paths, with a one-entry commit stage and pending flags.
//
//   state | meaning
//   EMPTY | no buffered write; a granted non-R0 write loads the stage
//   FULL  | stage holds a write; commits each cycle wb_stall is low
module regfile_write_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                wb_stall,
    output logic [ADDR_W-1:0]   reg_write,
    output logic [DATA_W-1:0]   in_data,
    output logic                reg_write_signal,
    output logic [NUM_REGS-1:0] pending
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state;
    logic                rr_ptr;
    logic                accept_ok;
    logic                grant0;
    logic                grant1;
    logic                grant_any;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_data;

    // A reset cycle neither accepts nor commits, so a buffered write is discarded.
    assign accept_ok = !rst && ((state == EMPTY) || !wb_stall);

    assign grant0    = accept_ok && req0_valid && (!req1_valid || !rr_ptr);
    assign grant1    = accept_ok && req1_valid && (!req0_valid ||  rr_ptr);
    assign grant_any = grant0 || grant1;

    assign grant_addr = grant0 ? req0_addr : req1_addr;
    assign grant_data = grant0 ? req0_data : req1_data;

    assign req0_ready       = grant0;
    assign req1_ready       = grant1;
    assign reg_write_signal = !rst && (state == FULL) && !wb_stall;

    always_comb begin
        pending = '0;
        if (state == FULL) begin
            pending[reg_write] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            rr_ptr    <= 1'b0;
            reg_write <= '0;
            in_data   <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= grant0;
            end
            // R0 writes complete the handshake but never occupy the stage.
            if (grant_any && (grant_addr != '0)) begin
                state     <= FULL;
                reg_write <= grant_addr;
                in_data   <= grant_data;
            end else if ((state == FULL) && !wb_stall) begin
                state <= EMPTY;
            end
        end
    end

endmodule
